// File: rtl/packet_sipo184_pkg.sv
// Shared LiDAR framing definitions: packet length and the receive/transmit FSM encodings
// used by both the 184-bit SIPO receiver and the matching PISO transmitter.
package packet_sipo184_pkg;

  localparam int PKT_BITS = 184;
  localparam int CNT_W    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/packet_sipo184_bit_counter.sv
// Bit counter for the SIPO receiver: clear beats load-to-one, which beats increment.
// o_term flags that the counter holds TERM, i.e. the next accepted bit closes the frame.
module bit_counter #(
  parameter int WIDTH = 8,
  parameter int TERM  = 183
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_load,
  input  logic i_inc,
  output logic o_term
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= WIDTH'(1);
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_term = (r_count == WIDTH'(TERM));

endmodule

// File: rtl/packet_sipo184.sv
// Serial-in parallel-out receiver for 184-bit LiDAR packets, MSB first, framed by start
// and paced by bit_en; holds the last completed packet until acknowledged.
module packet_sipo184 #(
  parameter int PKT_BITS = packet_sipo184_pkg::PKT_BITS,
  parameter int CNT_W    = packet_sipo184_pkg::CNT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sdata,
  input  logic                bit_en,
  input  logic                start,
  input  logic                packet_ack,
  output logic [PKT_BITS-1:0] packet_out,
  output logic                packet_valid,
  output logic                busy,
  output logic                framing_err,
  output logic                overrun,
  output logic [CNT_W-1:0]    packet_count
);

  import packet_sipo184_pkg::*;

  state_t              r_state;
  state_t              w_nextState;
  logic                w_load;
  logic                w_shift;
  logic                w_complete;
  logic                w_abort;
  logic                w_term;
  logic [PKT_BITS-1:0] r_shiftReg;
  logic [PKT_BITS-1:0] w_assembled;
  logic [PKT_BITS-1:0] r_packetOut;
  logic                r_packetValid;
  logic                r_framingErr;
  logic                r_overrun;
  logic [CNT_W-1:0]    r_packetCount;

  bit_counter #(
    .WIDTH (CNT_W),
    .TERM  (PKT_BITS - 1)
  ) u_bitCounter (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_complete),
    .i_load  (w_load),
    .i_inc   (w_shift),
    .o_term  (w_term)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A start seen mid-frame restarts the frame on the same bit, so no bit is lost.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_complete  = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bit_en && start) begin
          w_load      = 1'b1;
          w_nextState = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_en) begin
          if (start) begin
            w_load  = 1'b1;
            w_abort = 1'b1;
          end else if (w_term) begin
            w_complete  = 1'b1;
            w_nextState = ST_IDLE;
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign w_assembled = {r_shiftReg[PKT_BITS-2:0], sdata};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shiftReg <= '0;
    end else if (w_load) begin
      r_shiftReg <= {{(PKT_BITS-1){1'b0}}, sdata};
    end else if (w_shift || w_complete) begin
      r_shiftReg <= w_assembled;
    end
  end

  // A completion wins over a simultaneous acknowledge so the fresh packet stays valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_packetOut   <= '0;
      r_packetValid <= 1'b0;
      r_framingErr  <= 1'b0;
      r_overrun     <= 1'b0;
      r_packetCount <= '0;
    end else begin
      r_framingErr <= w_abort;
      if (w_complete) begin
        r_packetOut   <= w_assembled;
        r_packetValid <= 1'b1;
        r_packetCount <= r_packetCount + CNT_W'(1);
        if (r_packetValid && !packet_ack) begin
          r_overrun <= 1'b1;
        end
      end else if (packet_ack) begin
        r_packetValid <= 1'b0;
      end
    end
  end

  assign packet_out   = r_packetOut;
  assign packet_valid = r_packetValid;
  assign busy         = (r_state == ST_SHIFT);
  assign framing_err  = r_framingErr;
  assign overrun      = r_overrun;
  assign packet_count = r_packetCount;

endmodule

// File: tb/tb_packet_sipo184.sv
// Directed bench for packet_sipo184: framing, gaps, abort, overrun, reset and a
// loopback from a bench-side PISO model over 256 random packets.
module tb_packet_sipo184;

  localparam logic [183:0] PAT_ONES  = {184{1'b1}};
  localparam logic [183:0] PAT_ZEROS = {184{1'b0}};
  localparam logic [183:0] PAT_A5    = {23{8'hA5}};
  localparam logic [183:0] PAT_3C    = {23{8'h3C}};

  logic         clk = 1'b0;
  logic         reset;
  logic         sdata;
  logic         bit_en;
  logic         start;
  logic         packet_ack;
  logic [183:0] packet_out;
  logic         packet_valid;
  logic         busy;
  logic         framing_err;
  logic         overrun;
  logic [7:0]   packet_count;

  int checkCount = 0;
  int errorCount = 0;

  packet_sipo184 dut (
    .clk          (clk),
    .reset        (reset),
    .sdata        (sdata),
    .bit_en       (bit_en),
    .start        (start),
    .packet_ack   (packet_ack),
    .packet_out   (packet_out),
    .packet_valid (packet_valid),
    .busy         (busy),
    .framing_err  (framing_err),
    .overrun      (overrun),
    .packet_count (packet_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [183:0] obs, input logic [183:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one bit for exactly one rising edge, then returns 1 ns after that edge.
  task automatic applyStimulus(input logic b, input logic st);
    sdata  = b;
    start  = st;
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    start  = 1'b0;
    sdata  = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyReset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic pulseAck();
    packet_ack = 1'b1;
    @(posedge clk);
    #1;
    packet_ack = 1'b0;
  endtask

  // busyLow counts sampled points inside the frame where busy was not asserted.
  task automatic sendPacket(input logic [183:0] w, input int gap, input logic ackLast,
                            output int busyLow);
    busyLow = 0;
    for (int i = 183; i >= 0; i--) begin
      packet_ack = ackLast && (i == 0);
      applyStimulus(w[i], i == 183);
      packet_ack = 1'b0;
      if (i != 0 && !busy) busyLow++;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        #1;
        if (i != 0 && !busy) busyLow++;
      end
    end
  endtask

  initial begin
    int           busyLow;
    logic [183:0] txReg;
    logic [183:0] word;
    logic [191:0] wide;
    int           loopErrs;

    reset      = 1'b1;
    sdata      = 1'b0;
    bit_en     = 1'b0;
    start      = 1'b0;
    packet_ack = 1'b0;
    idleCycles(2);
    checkOutput("rst_out", packet_out, PAT_ZEROS);
    checkOutput("rst_valid", 184'(packet_valid), 184'(0));
    checkOutput("rst_busy", 184'(busy), 184'(0));
    checkOutput("rst_ferr", 184'(framing_err), 184'(0));
    checkOutput("rst_ovr", 184'(overrun), 184'(0));
    checkOutput("rst_cnt", 184'(packet_count), 184'(0));
    reset = 1'b0;

    // Bits without start are ignored in IDLE.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("nostart_busy", 184'(busy), 184'(0));
    checkOutput("nostart_valid", 184'(packet_valid), 184'(0));

    // Continuous A5 packet.
    sendPacket(PAT_A5, 0, 1'b0, busyLow);
    checkOutput("a5_out", packet_out, PAT_A5);
    checkOutput("a5_valid", 184'(packet_valid), 184'(1));
    checkOutput("a5_cnt", 184'(packet_count), 184'(1));
    checkOutput("a5_busy_done", 184'(busy), 184'(0));
    checkOutput("a5_busy_frame", 184'(busyLow), 184'(0));
    pulseAck();
    checkOutput("ack_clears", 184'(packet_valid), 184'(0));
    pulseAck();
    checkOutput("ack_idle_valid", 184'(packet_valid), 184'(0));
    checkOutput("ack_idle_ovr", 184'(overrun), 184'(0));

    // Same packet, one bit every third cycle.
    sendPacket(PAT_A5, 2, 1'b0, busyLow);
    checkOutput("gap_out", packet_out, PAT_A5);
    checkOutput("gap_busy_frame", 184'(busyLow), 184'(0));
    checkOutput("gap_cnt", 184'(packet_count), 184'(2));
    checkOutput("gap_ovr", 184'(overrun), 184'(0));

    // Abort at bit 100, then a full all-ones packet.
    applyReset();
    for (int i = 0; i < 99; i++) applyStimulus(1'b0, i == 0);
    applyStimulus(1'b1, 1'b1);
    checkOutput("abort_ferr", 184'(framing_err), 184'(1));
    checkOutput("abort_out_held", packet_out, PAT_ZEROS);
    for (int i = 182; i >= 0; i--) begin
      applyStimulus(1'b1, 1'b0);
      if (i == 182) checkOutput("abort_ferr_pulse", 184'(framing_err), 184'(0));
    end
    checkOutput("abort_out", packet_out, PAT_ONES);
    checkOutput("abort_cnt", 184'(packet_count), 184'(1));

    // Overrun: two packets, no acknowledge.
    applyReset();
    sendPacket(PAT_ZEROS, 0, 1'b0, busyLow);
    checkOutput("ovr_first", 184'(overrun), 184'(0));
    sendPacket(PAT_ONES, 0, 1'b0, busyLow);
    checkOutput("ovr_out", packet_out, PAT_ONES);
    checkOutput("ovr_set", 184'(overrun), 184'(1));
    checkOutput("ovr_cnt", 184'(packet_count), 184'(2));
    pulseAck();
    checkOutput("ovr_ack_valid", 184'(packet_valid), 184'(0));
    checkOutput("ovr_sticky", 184'(overrun), 184'(1));

    // Acknowledge coinciding with completion keeps the new packet valid, no overrun.
    applyReset();
    sendPacket(PAT_A5, 0, 1'b0, busyLow);
    sendPacket(PAT_3C, 0, 1'b1, busyLow);
    checkOutput("ackcomp_out", packet_out, PAT_3C);
    checkOutput("ackcomp_valid", 184'(packet_valid), 184'(1));
    checkOutput("ackcomp_ovr", 184'(overrun), 184'(0));

    // Reset at bit 90 of a frame following a completed packet.
    applyReset();
    sendPacket(PAT_A5, 0, 1'b0, busyLow);
    for (int i = 0; i < 89; i++) applyStimulus(1'b1, i == 0);
    reset = 1'b1;
    #1;
    checkOutput("midrst_out", packet_out, PAT_ZEROS);
    checkOutput("midrst_valid", 184'(packet_valid), 184'(0));
    checkOutput("midrst_busy", 184'(busy), 184'(0));
    checkOutput("midrst_cnt", 184'(packet_count), 184'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0);
    checkOutput("postrst_busy", 184'(busy), 184'(0));
    checkOutput("postrst_valid", 184'(packet_valid), 184'(0));
    checkOutput("postrst_ferr", 184'(framing_err), 184'(0));
    sendPacket(PAT_3C, 0, 1'b0, busyLow);
    checkOutput("postrst_out", packet_out, PAT_3C);
    checkOutput("postrst_cnt", 184'(packet_count), 184'(1));

    // Loopback through a bench-side PISO model, packets back to back.
    applyReset();
    loopErrs = 0;
    for (int p = 0; p < 256; p++) begin
      wide  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      word  = wide[183:0];
      txReg = word;
      for (int i = 0; i < 184; i++) begin
        applyStimulus(txReg[183], i == 0);
        txReg = {txReg[182:0], 1'b0};
      end
      if (packet_out !== word) loopErrs++;
      if (p < 4) checkOutput("loop_out", packet_out, word);
    end
    checkOutput("loop_mismatches", 184'(loopErrs), 184'(0));
    checkOutput("loop_cnt_wrap", 184'(packet_count), 184'(0));
    checkOutput("loop_ferr", 184'(framing_err), 184'(0));

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/packet_sipo184.md
PACKET_SIPO184 -- requirements
Module: packet_sipo184

Interface
REQ-001 Parameter: PKT_BITS, 184, packet length in bits.
REQ-002 Parameter: CNT_W, 8, width of bit counter and packet counter.
REQ-003 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high system reset.
REQ-005 Port: sdata  input  1  serial data bit, MSB of packet first.
REQ-006 Port: bit_en  input  1  bit strobe; sdata sampled only on clk edges where bit_en=1.
REQ-007 Port: start  input  1  frame marker; qualified by bit_en, marks the cycle carrying packet bit PKT_BITS-1 (MSB).
REQ-008 Port: packet_ack  input  1  consumer acknowledge of packet_out.
REQ-009 Port: packet_out  output  PKT_BITS  last completed packet.
REQ-010 Port: packet_valid  output  1  packet_out holds an unacknowledged packet.
REQ-011 Port: busy  output  1  high while in SHIFT state.
REQ-012 Port: framing_err  output  1  one-cycle pulse on aborted frame.
REQ-013 Port: overrun  output  1  sticky; a completed packet overwrote an unacknowledged one.
REQ-014 Port: packet_count  output  CNT_W  number of completed packets, mod 2^CNT_W.

Function
REQ-015 FSM states SHALL be IDLE and SHIFT; busy SHALL equal (state==SHIFT).
REQ-016 IDLE: bit_en=1 & start=1 -> SHIFT; shift register loads {zeros, sdata}; bit_cnt=1.
REQ-017 IDLE: bit_en=1 & start=0 SHALL be ignored (no state change).
REQ-018 SHIFT: bit_en=1 & start=0 -> shift register <= {sr[PKT_BITS-2:0], sdata}; bit_cnt+1.
REQ-019 SHIFT: bit_en=0 -> hold all state (gaps between bits of any length allowed).
REQ-020 Completion: on the edge sampling bit PKT_BITS (bit_cnt==PKT_BITS-1 and bit_en=1, start=0), packet_out SHALL load the full assembled word, packet_valid SHALL be set, packet_count SHALL increment (wrap 255->0), FSM -> IDLE; packet_out visible the cycle after the last bit is presented.
REQ-021 SHIFT: bit_en=1 & start=1 SHALL abort current frame, pulse framing_err for one cycle, and restart as in REQ-016 (bit_cnt=1); packet_out unchanged.
REQ-022 Bit order: first sampled bit SHALL appear at packet_out[PKT_BITS-1], last at packet_out[0].
REQ-023 packet_valid SHALL clear on the edge where packet_ack=1, unless a completion occurs in the same cycle, in which case it SHALL remain 1 with the new packet.
REQ-024 packet_ack while packet_valid=0 SHALL have no effect.
REQ-025 Completion while packet_valid=1 and packet_ack=0 SHALL overwrite packet_out and set overrun; overrun clears only on reset.
REQ-026 Back-to-back: start with bit_en in the cycle immediately following completion SHALL begin a new frame with no lost bit.

Reset
REQ-027 reset=1 SHALL asynchronously force: state=IDLE, shift register=0, bit_cnt=0, packet_out=0, packet_valid=0, busy=0, framing_err=0, overrun=0, packet_count=0.
REQ-028 Reset mid-frame SHALL discard partial data; no framing_err or packet_valid is produced on release.
REQ-029 First frame after reset release SHALL require start; bits before it are ignored.

Structure
REQ-030 Shared LiDAR package SHALL hold PKT_BITS (184) and FSM state encodings, used also by the transmit-side 184-bit PISO.
REQ-031 One sub-module, bit_counter, SHALL implement the loadable/clearable bit counter with terminal-count flag; all else in packet_sipo184.

Verification
REQ-032 Send 184 bits of 0xA5 repeated (MSB first, bit_en every cycle, start on first) -> packet_out = 23 bytes 0xA5, packet_valid=1 one cycle after bit 184, packet_count=1.
REQ-033 Same packet with bit_en every 3rd cycle -> identical packet_out; busy high from first bit to completion.
REQ-034 Abort: start at bit 100, then full packet of 0xFF..FF -> framing_err one pulse, packet_out all-ones, packet_count=1.
REQ-035 Two packets (0x00.., then 0xFF..) without packet_ack -> packet_out all-ones, overrun=1, packet_count=2; packet_ack then clears packet_valid, overrun stays 1.
REQ-036 Assert reset at bit 90 of a frame -> all outputs 0 immediately; subsequent bits without start ignored; next start-framed packet received correctly.
REQ-037 Loopback: transmit-side PISO loaded with random 184-bit word, shifted into packet_sipo184 with start on first bit -> packet_out equals the loaded word over 256 random packets; packet_count wraps to 0.
